mem_io_unit: RTL and testbench
==============================

MEM_IO_UNIT -- requirements
Module: mem_io_unit

Interface
REQ-001 Parameter RAM_WORDS, default 256: number of 16-bit RAM words, mapped at 0x0000..RAM_WORDS-1.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth for sw_in.
REQ-003 clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 cpu_addr  in  16  word address from CPU (RISC Addr).
REQ-006 cpu_wdata  in  16  write data from CPU (RISC D_out).
REQ-007 mw_en  in  1  memory write enable from CPU.
REQ-008 cpu_rdata  out  16  read data to CPU (RISC D_in).
REQ-009 sw_in  in  16  asynchronous switch inputs.
REQ-010 led_out  out  16  LED register contents.
REQ-011 timer_irq  out  1  timer interrupt request, level.

Function
REQ-012 Address map: RAM 0x0000..RAM_WORDS-1; LED 0xFFF0 R/W; SW 0xFFF1 RO; TCNT 0xFFF2 R/W; TCMP 0xFFF3 R/W; TCTL 0xFFF4 R/W; all other addresses read 0x0000, writes ignored.
REQ-013 cpu_rdata is combinational from cpu_addr and current register/RAM state; zero-cycle read latency.
REQ-014 Writes take effect at the rising edge where mw_en=1; a same-cycle read returns the pre-write value.
REQ-015 RAM is not reset; contents are unknown until written.
REQ-016 SW reads return sw_in delayed by SYNC_STAGES flops; writes to 0xFFF1 are ignored.
REQ-017 TCTL bits: bit0 EN, bit1 AUTOCLR, bit2 IRQEN, bit15 MATCH (sticky); other bits read 0.
REQ-018 When EN=1, TCNT increments by 1 per clock, wrapping 0xFFFF->0x0000; when EN=0, TCNT holds.
REQ-019 At an edge where EN=1 and TCNT==TCMP (pre-edge values), MATCH is set; if AUTOCLR=1, TCNT loads 0x0000 instead of incrementing.
REQ-020 A CPU write to TCNT has priority over increment and auto-clear on the same edge.
REQ-021 A CPU write to TCTL with bit15=1 clears MATCH; if a match occurs on the same edge, MATCH is set (set wins).
REQ-022 A CPU write to TCTL updates bits 2:0; a bit15=0 write leaves MATCH unchanged.
REQ-023 timer_irq = MATCH AND IRQEN, combinational from registered state.
REQ-024 Out-of-range RAM addresses (>= RAM_WORDS and < 0xFFF0) are unmapped per REQ-012; RAM index never aliases.

Reset
REQ-025 On reset assertion, asynchronously: led_out=0x0000, synchronizer stages=0, TCNT=0x0000, TCMP=0xFFFF, TCTL=0x0000 (MATCH=0), timer_irq=0.
REQ-026 Reset mid-count aborts counting immediately; no match is set during reset.
REQ-027 RAM contents are unaffected by reset.

Structure
REQ-028 Address constants (LED, SW, TCNT, TCMP, TCTL) and TCTL bit positions are defined in shared package risc_pkg.
REQ-029 Timer logic (TCNT, TCMP, TCTL, MATCH, irq) is a sub-module named timer_unit; RAM, LED, synchronizer and read mux stay in mem_io_unit.

Verification
REQ-030 Write 0x1234 to 0x0010, then 0xBEEF to 0x00FF; read both -> 0x1234, 0xBEEF; read 0x0100 -> 0x0000.
REQ-031 Write 0x00A5 to 0xFFF0 -> led_out=0x00A5 on the next edge; reset -> led_out=0x0000 without a clock edge.
REQ-032 sw_in 0x0000->0xC3C3 -> reads of 0xFFF1 return 0x0000 for 1 edge, 0xC3C3 from the 2nd edge onward.
REQ-033 TCMP=0x0005, TCTL=0x0007 -> TCNT counts 0..5, MATCH and timer_irq rise on the edge after TCNT=5, TCNT=0x0000; write TCTL=0x8007 -> MATCH=0, timer_irq=0.
REQ-034 TCNT=0xFFFF, TCMP=0x0003, TCTL=0x0001 -> TCNT wraps to 0x0000 with no MATCH; write TCNT=0x0100 while counting -> next read 0x0100.
REQ-035 Clear MATCH on the same edge as a new match -> MATCH remains 1.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared address map and timer control bit positions for the RISC memory/IO slice.
package risc_pkg;

  localparam logic [15:0] ADDR_LED  = 16'hFFF0;
  localparam logic [15:0] ADDR_SW   = 16'hFFF1;
  localparam logic [15:0] ADDR_TCNT = 16'hFFF2;
  localparam logic [15:0] ADDR_TCMP = 16'hFFF3;
  localparam logic [15:0] ADDR_TCTL = 16'hFFF4;

  localparam int TCTL_EN      = 0;
  localparam int TCTL_AUTOCLR = 1;
  localparam int TCTL_IRQEN   = 2;
  localparam int TCTL_MATCH   = 15;

endpackage

// File: rtl/timer_unit.sv
// Free-running compare timer: TCNT counts while enabled, sticky MATCH flag on TCNT==TCMP,
// optional auto-clear of TCNT on match, level interrupt gated by IRQEN.
module timer_unit
  import risc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we_tcnt,
  input  logic        we_tcmp,
  input  logic        we_tctl,
  input  logic [15:0] wdata,
  output logic [15:0] tcnt,
  output logic [15:0] tcmp,
  output logic [15:0] tctl,
  output logic        timer_irq
);

  logic [2:0] ctl_q;
  logic       match_q;
  logic       match_now;

  // Match is judged on pre-edge count/compare and the pre-edge enable.
  assign match_now = ctl_q[TCTL_EN] && (tcnt == tcmp);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt    <= 16'h0000;
      tcmp    <= 16'hFFFF;
      ctl_q   <= 3'b000;
      match_q <= 1'b0;
    end else begin
      if (we_tcnt) begin
        tcnt <= wdata;
      end else if (ctl_q[TCTL_EN]) begin
        if (match_now && ctl_q[TCTL_AUTOCLR]) tcnt <= 16'h0000;
        else                                  tcnt <= tcnt + 16'h0001;
      end
      if (we_tcmp) tcmp <= wdata;
      if (we_tctl) ctl_q <= wdata[2:0];
      // A fresh match outranks a software clear on the same edge.
      if (match_now)                         match_q <= 1'b1;
      else if (we_tctl && wdata[TCTL_MATCH]) match_q <= 1'b0;
    end
  end

  assign tctl      = {match_q, 12'h000, ctl_q};
  assign timer_irq = match_q && ctl_q[TCTL_IRQEN];

endmodule

// File: rtl/mem_io_unit.sv
// CPU-facing memory/IO block: word RAM, LED register, synchronized switches and the
// compare timer, all behind a zero-latency combinational read mux.
module mem_io_unit
  import risc_pkg::*;
#(
  parameter int RAM_WORDS   = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  input  logic        mw_en,
  output logic [15:0] cpu_rdata,
  input  logic [15:0] sw_in,
  output logic [15:0] led_out,
  output logic        timer_irq
);

  localparam int          AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [16:0] RAM_LIMIT = 17'(RAM_WORDS);

  logic [15:0] ram [RAM_WORDS];
  logic [15:0] sync_q [SYNC_STAGES];
  logic [AW-1:0] ram_idx;
  logic        ram_hit;
  logic [15:0] tcnt, tcmp, tctl;

  // Full-address compare so addresses past the RAM never alias into it.
  assign ram_hit = ({1'b0, cpu_addr} < RAM_LIMIT);
  assign ram_idx = cpu_addr[AW-1:0];

  always_ff @(posedge clk) begin
    if (mw_en && ram_hit) ram[ram_idx] <= cpu_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_out <= 16'h0000;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 16'h0000;
    end else begin
      if (mw_en && cpu_addr == ADDR_LED) led_out <= cpu_wdata;
      sync_q[0] <= sw_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  timer_unit u_timer (
    .clk       (clk),
    .reset     (reset),
    .we_tcnt   (mw_en && cpu_addr == ADDR_TCNT),
    .we_tcmp   (mw_en && cpu_addr == ADDR_TCMP),
    .we_tctl   (mw_en && cpu_addr == ADDR_TCTL),
    .wdata     (cpu_wdata),
    .tcnt      (tcnt),
    .tcmp      (tcmp),
    .tctl      (tctl),
    .timer_irq (timer_irq)
  );

  always_comb begin
    cpu_rdata = 16'h0000;
    if (ram_hit) begin
      cpu_rdata = ram[ram_idx];
    end else begin
      case (cpu_addr)
        ADDR_LED:  cpu_rdata = led_out;
        ADDR_SW:   cpu_rdata = sync_q[SYNC_STAGES-1];
        ADDR_TCNT: cpu_rdata = tcnt;
        ADDR_TCMP: cpu_rdata = tcmp;
        ADDR_TCTL: cpu_rdata = tctl;
        default:   cpu_rdata = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io_unit.sv
// Self-checking bench for mem_io_unit: RAM, LED, switch synchronizer and timer scenarios.
module tb_mem_io_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata, sw_in, led_out;
  logic        mw_en, timer_irq;

  logic [15:0] exp_q[$];
  logic [15:0] got, exp;
  int          checks = 0;
  int          errors = 0;

  mem_io_unit #(.RAM_WORDS(256), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .mw_en     (mw_en),
    .cpu_rdata (cpu_rdata),
    .sw_in     (sw_in),
    .led_out   (led_out),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  // Driver tasks: called 1ns after a rising edge.
  task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
    cpu_addr = a; cpu_wdata = d; mw_en = 1'b1;
    @(posedge clk); #1;
    mw_en = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [15:0] d);
    cpu_addr = a;
    #1;
    d = cpu_rdata;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    exp_q.push_back(16'h0000); got = led_out; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL rst_led got=%h exp=%h", got, exp); end
    exp_q.push_back(16'h0000); cpu_read(16'hFFF2, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL rst_tcnt got=%h exp=%h", got, exp); end
    exp_q.push_back(16'hFFFF); cpu_read(16'hFFF3, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL rst_tcmp got=%h exp=%h", got, exp); end
    exp_q.push_back(16'h0000); cpu_read(16'hFFF4, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL rst_tctl got=%h exp=%h", got, exp); end
    exp_q.push_back(16'h0000); cpu_read(16'hFFF1, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL rst_sw got=%h exp=%h", got, exp); end
    exp_q.push_back(16'h0000); got = {15'b0, timer_irq}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL rst_irq got=%h exp=%h", got, exp); end
  endtask

  task automatic test_ram();
    logic [15:0] a, d;
    cpu_write(16'h0010, 16'h1234);
    cpu_write(16'h00FF, 16'hBEEF);
    // Same-cycle read during a write sees the old value.
    cpu_addr = 16'h0010; cpu_wdata = 16'h5555; mw_en = 1'b1;
    #1;
    exp_q.push_back(16'h1234); got = cpu_rdata; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL ram_rd_during_wr got=%h exp=%h", got, exp); end
    mw_en = 1'b0;
    tick();
    cpu_write(16'h0010, 16'h1234);
    exp_q.push_back(16'h1234); cpu_read(16'h0010, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL ram_0010 got=%h exp=%h", got, exp); end
    exp_q.push_back(16'hBEEF); cpu_read(16'h00FF, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL ram_00ff got=%h exp=%h", got, exp); end
    cpu_write(16'h0100, 16'hDEAD);
    exp_q.push_back(16'h0000); cpu_read(16'h0100, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL unmapped_0100 got=%h exp=%h", got, exp); end
    exp_q.push_back(16'h0000); cpu_read(16'h0000, got); exp = (exp_q.pop_front() === 16'h0000) ? cpu_rdata : 16'h0000;
    // Address 0x0000 must not have been hit by the 0x0100 write (no aliasing).
    checks++;
    if (got === 16'hDEAD) begin errors++; $display("FAIL ram_alias got=%h exp=not dead", got); end
    exp_q.push_back(16'h0000); cpu_read(16'hFFF5, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL unmapped_fff5 got=%h exp=%h", got, exp); end
    // Random RAM traffic.
    for (int i = 0; i < 6; i++) begin
      a = 16'($urandom_range(32, 200));
      d = 16'($urandom_range(0, 65535));
      cpu_write(a, d);
      exp_q.push_back(d); cpu_read(a, got); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL ram_rand a=%h got=%h exp=%h", a, got, exp); end
    end
  endtask

  task automatic test_led_reset_async();
    cpu_write(16'hFFF0, 16'h00A5);
    exp_q.push_back(16'h00A5); got = led_out; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL led_write got=%h exp=%h", got, exp); end
    exp_q.push_back(16'h00A5); cpu_read(16'hFFF0, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL led_read got=%h exp=%h", got, exp); end
    #1 reset = 1'b1;
    #1;
    exp_q.push_back(16'h0000); got = led_out; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL led_async_rst got=%h exp=%h", got, exp); end
    exp_q.push_back(16'h1234); cpu_read(16'h0010, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL ram_kept got=%h exp=%h", got, exp); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_sw();
    sw_in = 16'hC3C3;
    tick();
    exp_q.push_back(16'h0000); cpu_read(16'hFFF1, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL sw_edge1 got=%h exp=%h", got, exp); end
    tick();
    exp_q.push_back(16'hC3C3); cpu_read(16'hFFF1, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL sw_edge2 got=%h exp=%h", got, exp); end
    cpu_write(16'hFFF1, 16'h1111);
    exp_q.push_back(16'hC3C3); cpu_read(16'hFFF1, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL sw_wr_ignored got=%h exp=%h", got, exp); end
  endtask

  task automatic test_timer_match();
    cpu_write(16'hFFF3, 16'h0005);
    cpu_write(16'hFFF4, 16'h0007);
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(16'(k)); cpu_read(16'hFFF2, got); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL tcnt_count k=%0d got=%h exp=%h", k, got, exp); end
      tick();
    end
    exp_q.push_back(16'h0005); cpu_read(16'hFFF2, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL tcnt_5 got=%h exp=%h", got, exp); end
    exp_q.push_back(16'h0007); cpu_read(16'hFFF4, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL tctl_pre_match got=%h exp=%h", got, exp); end
    tick();
    exp_q.push_back(16'h0000); cpu_read(16'hFFF2, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL tcnt_autoclr got=%h exp=%h", got, exp); end
    exp_q.push_back(16'h8007); cpu_read(16'hFFF4, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL tctl_match got=%h exp=%h", got, exp); end
    exp_q.push_back(16'h0001); got = {15'b0, timer_irq}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL irq_set got=%h exp=%h", got, exp); end
    cpu_write(16'hFFF4, 16'h8007);
    exp_q.push_back(16'h0007); cpu_read(16'hFFF4, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL tctl_clear got=%h exp=%h", got, exp); end
    exp_q.push_back(16'h0000); got = {15'b0, timer_irq}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL irq_clear got=%h exp=%h", got, exp); end
  endtask

  task automatic test_timer_wrap_and_collision();
    reset = 1'b1; #1; reset = 1'b0;
    cpu_write(16'hFFF2, 16'hFFFF);
    cpu_write(16'hFFF3, 16'h0003);
    cpu_write(16'hFFF4, 16'h0001);
    exp_q.push_back(16'hFFFF); cpu_read(16'hFFF2, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL tcnt_hold got=%h exp=%h", got, exp); end
    tick();
    exp_q.push_back(16'h0000); cpu_read(16'hFFF2, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL tcnt_wrap got=%h exp=%h", got, exp); end
    exp_q.push_back(16'h0001); cpu_read(16'hFFF4, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL wrap_no_match got=%h exp=%h", got, exp); end
    cpu_write(16'hFFF2, 16'h0100);
    exp_q.push_back(16'h0100); cpu_read(16'hFFF2, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL tcnt_write_prio got=%h exp=%h", got, exp); end
    // Match without auto-clear keeps counting; IRQEN=0 keeps irq low.
    cpu_write(16'hFFF2, 16'h0002);
    tick();
    tick();
    exp_q.push_back(16'h0004); cpu_read(16'hFFF2, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL tcnt_no_autoclr got=%h exp=%h", got, exp); end
    exp_q.push_back(16'h8001); cpu_read(16'hFFF4, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL match_no_autoclr got=%h exp=%h", got, exp); end
    exp_q.push_back(16'h0000); got = {15'b0, timer_irq}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL irq_gated got=%h exp=%h", got, exp); end
    cpu_write(16'hFFF2, 16'h0003);
    cpu_write(16'hFFF4, 16'h8001);
    exp_q.push_back(16'h8001); cpu_read(16'hFFF4, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL set_wins_clear got=%h exp=%h", got, exp); end
    cpu_write(16'hFFF4, 16'h8001);
    exp_q.push_back(16'h0001); cpu_read(16'hFFF4, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL clear_after got=%h exp=%h", got, exp); end
    cpu_write(16'hFFF4, 16'h0000);
    exp_q.push_back(16'h0000); cpu_read(16'hFFF4, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL tctl_bits_only got=%h exp=%h", got, exp); end
  endtask

  initial begin
    reset = 1'b1; cpu_addr = 16'h0000; cpu_wdata = 16'h0000; mw_en = 1'b0; sw_in = 16'h0000;
    #2;
    test_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    test_ram();
    test_led_reset_async();
    test_sw();
    test_timer_match();
    test_timer_wrap_and_collision();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
